// File: rtl/pipelined_adder_nbit.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_nbit
// Purpose  : Pipelined WIDTH-bit binary adder. Operands are split into
//            SEG-bit segments; one segment is summed per pipeline stage and
//            the carry is registered between stages. A valid strobe travels
//            alongside the data. One operand pair is accepted every clock,
//            with no backpressure and no stalls.
//
// Parameters:
//   WIDTH     operand / sum width, must be a positive multiple of SEG
//   SEG       bits summed per pipeline stage
//   (STAGES = WIDTH/SEG is derived internally)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   a/b/cin carry a valid operand pair this cycle
//   a, b       in   WIDTH-bit operands (unsigned or two's complement)
//   cin        in   carry into bit 0
//   out_valid  out  s/cout (and ovf) hold a newly completed result
//   s          out  a + b + cin modulo 2^WIDTH
//   cout       out  carry out of bit WIDTH-1
//   ovf        out  two's-complement overflow, only when the macro
//                   PIPELINED_ADDER_OVF_EN is defined
//
// Latency    : in_valid sampled at edge n -> out_valid in the cycle after
//              edge n+STAGES.
// Revision   : 1.0  initial release
// ============================================================================
module pipelined_adder_nbit #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  // --------------------------------------------------------------------------
  // Stage 0: input capture register
  // --------------------------------------------------------------------------
  logic             in_v;
  logic             in_c;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  // --------------------------------------------------------------------------
  // Adder stages. Array index j holds the registers of adder stage j+1.
  //   st_a/st_b : operand bits not yet consumed, shifted down so the next
  //               segment to add always sits in bits [SEG-1:0] (skew).
  //   st_sum    : completed sum segments. Each new segment enters at the top
  //               and earlier ones shift down, so after the last stage the
  //               first segment lands in bits [SEG-1:0] (deskew).
  // --------------------------------------------------------------------------
  logic             st_v   [STAGES];
  logic             st_c   [STAGES];
  logic [WIDTH-1:0] st_sum [STAGES];
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];

  // Inputs seen by each adder stage (outputs of the preceding register).
  logic             prev_v   [STAGES];
  logic             prev_c   [STAGES];
  logic [WIDTH-1:0] prev_sum [STAGES];
  logic [WIDTH-1:0] prev_a   [STAGES];
  logic [WIDTH-1:0] prev_b   [STAGES];

  // Per-stage segment result, bit SEG is the segment carry out.
  logic [SEG:0]     seg_full [STAGES];
  logic [WIDTH-1:0] next_sum [STAGES];

  always_comb begin
    prev_v   = '{default: 1'b0};
    prev_c   = '{default: 1'b0};
    prev_sum = '{default: '0};
    prev_a   = '{default: '0};
    prev_b   = '{default: '0};
    seg_full = '{default: '0};
    next_sum = '{default: '0};

    // The first adder stage is fed by the input register and starts with an
    // empty sum accumulator; later stages are fed by their predecessor.
    prev_v[0]   = in_v;
    prev_c[0]   = in_c;
    prev_a[0]   = in_a;
    prev_b[0]   = in_b;
    prev_sum[0] = '0;
    for (int j = 1; j < STAGES; j++) begin
      prev_v[j]   = st_v[j-1];
      prev_c[j]   = st_c[j-1];
      prev_a[j]   = st_a[j-1];
      prev_b[j]   = st_b[j-1];
      prev_sum[j] = st_sum[j-1];
    end

    for (int j = 0; j < STAGES; j++) begin
      seg_full[j] = {1'b0, prev_a[j][SEG-1:0]}
                  + {1'b0, prev_b[j][SEG-1:0]}
                  + (SEG+1)'(prev_c[j]);
      next_sum[j] = (prev_sum[j] >> SEG)
                  | (WIDTH'(seg_full[j][SEG-1:0]) << (WIDTH - SEG));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_v <= 1'b0;
      in_c <= 1'b0;
      in_a <= '0;
      in_b <= '0;
      for (int j = 0; j < STAGES; j++) begin
        st_v[j]   <= 1'b0;
        st_c[j]   <= 1'b0;
        st_sum[j] <= '0;
        st_a[j]   <= '0;
        st_b[j]   <= '0;
      end
    end else begin
      in_v <= in_valid;
      if (in_valid) begin
        in_a <= a;
        in_b <= b;
        in_c <= cin;
      end
      // Valid always advances; data only moves behind a valid, so the last
      // stage (and hence s/cout) holds the previous result across bubbles.
      for (int j = 0; j < STAGES; j++) begin
        st_v[j] <= prev_v[j];
        if (prev_v[j]) begin
          st_c[j]   <= seg_full[j][SEG];
          st_sum[j] <= next_sum[j];
          st_a[j]   <= prev_a[j] >> SEG;
          st_b[j]   <= prev_b[j] >> SEG;
        end
      end
    end
  end

  assign out_valid = st_v[LAST];
  assign s         = st_sum[LAST];
  assign cout      = st_c[LAST];

`ifdef PIPELINED_ADDER_OVF_EN
  // Carry into bit WIDTH-1 recovered from the MSB sum bit: c = a ^ b ^ s.
  // In the last stage the operand MSBs sit at bit SEG-1 of the shifted skew.
  logic msb_carry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msb_carry <= 1'b0;
    end else if (prev_v[LAST]) begin
      msb_carry <= prev_a[LAST][SEG-1] ^ prev_b[LAST][SEG-1]
                 ^ seg_full[LAST][SEG-1];
    end
  end

  assign ovf = msb_carry ^ st_c[LAST];
`endif

endmodule
`default_nettype wire

// File: doc/pipelined_adder_nbit.md
# pipelined_adder_nbit

Parametrised, pipelined N-bit binary adder and the successor to the single-bit half adder. Operands are split into SEG-bit segments, and one segment is summed per pipeline stage with the carry registered between stages. A valid strobe travels with the data. It accepts one operand pair per clock and is the arithmetic building block for the team's wider datapaths.

## Interface
- WIDTH, 16: operand and sum width in bits. Must be a positive multiple of SEG.
- SEG, 4: bits summed per pipeline stage. STAGES = WIDTH/SEG (derived, not overridable).
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  operand pair on a/b/cin is valid this cycle
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  s/cout (and ovf) carry a completed result this cycle
- s  output  WIDTH  sum a+b+cin modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow; present only with PIPELINED_ADDER_OVF_EN

## Operation
- Stage 0 is the input capture register. At each edge it loads a, b, cin and in_valid.
- Stage k (1..STAGES) adds segment k-1 of a and b plus the carry from stage k-1 (cin for k=1). It registers the SEG-bit partial sum and the carry out.
- Operand segments not yet consumed ride forward in skew registers. Completed sum segments ride forward in deskew registers. All STAGES segments of one operand pair emerge together from stage STAGES.
- The valid bit shifts one stage per edge. Stage data registers load only when the preceding stage's valid is 1. Otherwise they hold.
- There is no backpressure. The block accepts one operand pair every cycle and never stalls.
- s and cout are the stage-STAGES registers. They change only on edges where a valid result arrives, and otherwise hold the last result.
- Arithmetic is pure binary addition, and wrap-around is modulo 2^WIDTH. cout reports the carry, and the block does no saturation.
- Boundaries:
  - all-ones + 1: the carry ripples through every stage, giving s=0 and cout=1.
  - cin=1 with a=b=0: s=1.
  - SEG=WIDTH: degenerates to STAGES=1, i.e. an input register plus one adder stage.

## Timing
- Latency: in_valid=1 sampled at edge n makes out_valid=1 for exactly the cycle following edge n+STAGES.
- Throughput: one result per cycle. N back-to-back inputs produce N consecutive out_valid cycles in input order.
- Gaps in in_valid reproduce as identical gaps in out_valid.
- Reset: rst_n=0 at an edge clears every valid bit, data, skew, deskew and carry register to 0.
  - Outputs then read out_valid=0, s=0, cout=0, ovf=0.
  - Operand pairs in flight are discarded and never produce out_valid.
- in_valid asserted in the same cycle as rst_n=0 is ignored.
- The first accepted input after reset release is sampled at the first edge with rst_n=1.

## Configuration
- PIPELINED_ADDER_OVF_EN defined:
  - Port ovf exists.
  - The last stage also registers the carry into bit WIDTH-1. ovf = that carry XOR cout, i.e. two's-complement overflow.
  - ovf is aligned with s/cout, resets to 0, and holds like s.
- Not defined: the ovf port and its register are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=16, SEG=4, so STAGES=4.
1. Reset: hold rst_n=0 for 3 edges with random inputs and in_valid=1 -> out_valid=0, s=0x0000, cout=0 throughout.
2. Single add: a=0x00FF, b=0x0001, cin=0, in_valid for one edge n -> out_valid=1 only after edge n+4, s=0x0100, cout=0. Outputs hold afterwards.
3. Full carry chain: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1. Also a=0x0000, b=0x0000, cin=1 -> s=0x0001, cout=0.
4. Back-to-back and bubbles: present 0x1234+0x1111, then 0xF000+0x1000, then a one-cycle gap, then 0x8000+0x8000 -> out_valid pattern 1,1,0,1 with results 0x2345/0, 0x0000/1, 0x0000/1.
5. Reset mid-operation: issue 3 inputs, drop rst_n for one edge two cycles later, then release -> no out_valid for any of the 3. The next input after release returns correctly 4 cycles later.
6. With PIPELINED_ADDER_OVF_EN: 0x7FFF+0x0001 -> s=0x8000, cout=0, ovf=1. 0xFFFF+0xFFFF -> s=0xFFFE, cout=1, ovf=0.
